// File: rtl/mult_32_shift_add.sv
// Unsigned 32x32->64 shift-and-add multiplier: one multiplier bit per clock,
// with a 32-bit carry-lookahead adder as the only arithmetic element.

// 4-bit carry-lookahead group with group propagate/generate outputs.
module cla_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       pg,
    output logic       gg
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign s  = p ^ c;
    assign pg = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

// 32-bit adder: eight 4-bit lookahead groups chained on group P/G.
module CLA_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [7:0] gp;
    logic [7:0] gg;
    logic [8:0] carry;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_grp
            cla_4 u_grp (
                .a   (a[4*i +: 4]),
                .b   (b[4*i +: 4]),
                .cin (carry[i]),
                .s   (sum[4*i +: 4]),
                .pg  (gp[i]),
                .gg  (gg[i])
            );
            assign carry[i+1] = gg[i] | (gp[i] & carry[i]);
        end
    endgenerate

    assign cout = carry[8];
endmodule

module mult_32_shift_add (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] mcand;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [5:0]  count;

    logic [31:0] addend;
    logic [31:0] s;
    logic        c;

    // acc_lo[0] is the current multiplier bit; the consumed bits shift out
    // as product bits shift in from the top.
    assign addend = acc_lo[0] ? mcand : 32'h0;

    CLA_32 u_cla (
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (s),
        .cout (c)
    );

    assign product = {acc_hi, acc_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= 32'h0;
            acc_hi    <= 32'h0;
            acc_lo    <= 32'h0;
            count     <= 6'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a;
                        acc_lo   <= b;
                        acc_hi   <= 32'h0;
                        count    <= 6'd0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // Carry-out lands in bit 31 so the 33-bit sum is never truncated.
                    {acc_hi, acc_lo} <= {c, s, acc_lo[31:1]};
                    count            <= count + 6'd1;
                    if (count == 6'd31) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_32_shift_add.sv
// Bench for mult_32_shift_add: directed vector table, hand-written corner
// sequences and random operands checked against a plain-arithmetic model.
module tb_mult_32_shift_add;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int passed = 0;
    int total  = 0;

    mult_32_shift_add dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (op_a),
        .b         (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          hold;
    } vec_t;

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        return 64'(x) * 64'(y);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Steps until out_valid, bounded; returns cycles since the accept edge.
    task automatic wait_out(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!out_valid && n < 40);
    endtask

    // hold=0 keeps out_ready high throughout; hold>0 stalls that many cycles.
    task automatic run_txn(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic [63:0] exp, input int hold);
        int n;
        logic [63:0] held;
        check({name, "_idle"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        op_a      = x;
        op_b      = y;
        out_ready = (hold == 0);
        step();
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        check({name, "_accepted"}, 64'({in_ready, busy}), 64'b01);
        wait_out(n);
        check({name, "_latency"}, 64'(n), 64'd32);
        check({name, "_product"}, product, exp);
        held = product;
        for (int i = 0; i < hold; i++) begin
            step();
            check({name, "_stall"}, {product[61:0], out_valid, in_ready}, {held[61:0], 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        step();
        check({name, "_retired"}, 64'({out_valid, in_ready, busy}), 64'b010);
        check({name, "_kept"}, product, held);
        out_ready = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        int n;
        logic [63:0] held;
        logic [31:0] ra, rb;

        vecs.push_back('{32'd3,         32'd5,         64'd15,                  0});
        vecs.push_back('{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001,   0});
        vecs.push_back('{32'h80000000,  32'd2,         64'h00000001_00000000,   0});
        vecs.push_back('{32'hDEADBEEF,  32'd0,         64'd0,                   2});
        vecs.push_back('{32'd1,         32'h80000001,  64'h00000000_80000001,   1});

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = 32'h0; op_b = 32'h0;

        // Reset with random inputs wiggling
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            op_a      = $urandom;
            op_b      = $urandom;
            step();
        end
        check("reset_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
        check("reset_product", product, 64'h0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();

        foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);

        // Backpressure with a stray operand pulse while the result waits
        run_txn("bp_warm", 32'd2, 32'd3, 64'd6, 0);
        in_valid = 1'b1; op_a = 32'h12345678; op_b = 32'h9ABCDEF0; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        wait_out(n);
        check("bp_latency", 64'(n), 64'd32);
        check("bp_product", product, 64'h0B00EA4E_242D2080);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3 || i == 4);
            op_a = 32'd11; op_b = 32'd13;
            step();
            check("bp_hold", {product[61:0], out_valid, in_ready}, {62'h0B00EA4E_242D2080, 1'b1, 1'b0});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("bp_retire", 64'({out_valid, in_ready, busy}), 64'b010);
        check("bp_product_kept", product, 64'h0B00EA4E_242D2080);
        out_ready = 1'b0;

        // Reset mid-operation on iteration 16
        in_valid = 1'b1; op_a = 32'd100; op_b = 32'd200; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (15) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
        check("midrst_product", product, 64'h0);
        held = 64'h0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) held = held + 64'd1;
        end
        check("midrst_no_valid", held, 64'h0);
        run_txn("midrst_next", 32'd7, 32'd9, 64'd63, 0);

        // Zero operand, then back-to-back accept with in_valid held high
        in_valid = 1'b1; op_a = 32'h0; op_b = 32'hDEADBEEF; out_ready = 1'b1;
        step();
        op_a = 32'd1; op_b = 32'hFFFFFFFF;
        wait_out(n);
        check("zero_latency", 64'(n), 64'd32);
        check("zero_product", product, 64'h0);
        step();
        check("b2b_handshake", 64'({out_valid, in_ready, busy}), 64'b010);
        step();
        check("b2b_accept", 64'({in_ready, busy}), 64'b01);
        in_valid = 1'b0;
        wait_out(n);
        check("b2b_latency", 64'(n), 64'd32);
        check("b2b_product", product, 64'h00000000_FFFFFFFF);
        step();
        check("b2b_one_cycle", 64'({out_valid, in_ready}), 64'b01);
        out_ready = 1'b0;

        // Random operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) ra = ra >> $urandom_range(31, 0);
            run_txn($sformatf("rand%0d", i), ra, rb, model(ra, rb), int'($urandom_range(3, 0)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
